// File: rtl/am_meas_pkg.sv
// Shared constants, state encoding and result helpers for the AM tone frequency meter.
package am_meas_pkg;

    localparam int unsigned SYS_CLK_KHZ = 8192;
    localparam int unsigned MID_CODE    = 512;
    localparam int unsigned DIN_W       = 10;
    localparam int unsigned FREQ_W      = 8;
    localparam int unsigned PER_W       = 20;
    localparam int unsigned DIV_W       = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_MEAS = 2'd2
    } meas_state_e;

    // Clamp a divider quotient to the 8-bit kHz result range.
    function automatic logic [FREQ_W-1:0] sat_freq(input logic [DIV_W-1:0] q);
        return (q > 32'd255) ? '1 : q[FREQ_W-1:0];
    endfunction

endpackage

// File: rtl/seq_udiv.sv
// Unsigned restoring divider, one quotient bit per clock, with synchronous abort.
module seq_udiv #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quotient,
    output logic         done,
    output logic         busy
);

    localparam int unsigned CW = $clog2(W + 1);

    logic [W-1:0]  rem_q;
    logic [W-1:0]  quo_q;
    logic [W-1:0]  dvs_q;
    logic [CW-1:0] cnt_q;
    logic [W:0]    rem_shift;
    logic [W:0]    rem_sub;

    // Trial subtraction for the next quotient bit; MSB set means borrow.
    always_comb begin
        rem_shift = {rem_q, quo_q[W-1]};
        rem_sub   = rem_shift - {1'b0, dvs_q};
    end

    // Iterate W times after start, then spend one cycle raising done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                busy  <= 1'b0;
                cnt_q <= '0;
            end else if (start && !busy) begin
                rem_q <= '0;
                quo_q <= dividend;
                dvs_q <= divisor;
                cnt_q <= CW'(W);
                busy  <= 1'b1;
            end else if (busy) begin
                if (cnt_q != '0) begin
                    rem_q <= rem_sub[W] ? rem_shift[W-1:0] : rem_sub[W-1:0];
                    quo_q <= {quo_q[W-2:0], ~rem_sub[W]};
                    cnt_q <= cnt_q - 1'b1;
                end else begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign quotient = quo_q;

endmodule

// File: rtl/am_freq_meter.sv
// Modulating-tone frequency meter: Schmitt zero-crossing detector, NPER-period
// cycle count and rounded sequential divide into integer kHz.
module am_freq_meter
    import am_meas_pkg::*;
#(
    parameter int unsigned CLK_KHZ     = SYS_CLK_KHZ,
    parameter int unsigned NPER        = 4,
    parameter int unsigned HYST        = 16,
    parameter int unsigned TIMEOUT_CYC = 65536
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [9:0]  demod_in,
    input  logic        din_valid,
    output logic [7:0]  freq_khz,
    output logic [19:0] period_cyc,
    output logic        freq_valid,
    output logic        no_signal,
    output logic        busy
);

    localparam int unsigned EDGE_W = (NPER > 1) ? $clog2(NPER) : 1;
    localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYC) + 1;

    localparam logic [DIN_W-1:0]  HI_THR    = DIN_W'(MID_CODE + HYST);
    localparam logic [DIN_W-1:0]  LO_THR    = DIN_W'(MID_CODE - HYST);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(NPER - 1);
    localparam logic [DIV_W-1:0]  DIV_NUM   = DIV_W'(CLK_KHZ * NPER);

    meas_state_e       state_q;
    meas_state_e       state_nxt;
    logic              schmitt_q;
    logic              rise_q;
    logic [PER_W-1:0]  win_q;
    logic [PER_W-1:0]  win_inc;
    logic [PER_W-1:0]  per_next;
    logic [EDGE_W-1:0] edge_q;
    logic [TMO_W-1:0]  since_q;
    logic              win_done;
    logic              timeout;
    logic [DIV_W-1:0]  div_quo;
    logic              div_done;
    logic              div_busy;

    // Hysteresis comparator on qualified samples; rise is a registered one-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            schmitt_q <= 1'b0;
            rise_q    <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            if (din_valid) begin
                if (demod_in >= HI_THR) begin
                    schmitt_q <= 1'b1;
                    rise_q    <= ~schmitt_q;
                end else if (demod_in < LO_THR) begin
                    schmitt_q <= 1'b0;
                end
            end
        end
    end

    // Saturating window count and the period value latched at window end.
    always_comb begin
        win_inc  = (win_q == '1) ? win_q : win_q + 1'b1;
        per_next = (win_q == '1) ? win_q : win_q + 1'b1;
    end

    // Next-state and event strobes; a rise always beats a coincident timeout.
    always_comb begin
        state_nxt = state_q;
        win_done  = 1'b0;
        timeout   = 1'b0;
        if (!en) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_nxt = ST_ARM;
                ST_ARM: begin
                    if (rise_q) begin
                        state_nxt = ST_MEAS;
                    end else if (since_q == TMO_LAST) begin
                        timeout = 1'b1;
                    end
                end
                ST_MEAS: begin
                    if (rise_q) begin
                        win_done = (edge_q == EDGE_LAST);
                    end else if (since_q == TMO_LAST) begin
                        timeout   = 1'b1;
                        state_nxt = ST_ARM;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Window, edge and since-last-rise counters; all held at zero while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q   <= '0;
            edge_q  <= '0;
            since_q <= '0;
        end else if (!en || state_q == ST_IDLE) begin
            win_q   <= '0;
            edge_q  <= '0;
            since_q <= '0;
        end else begin
            since_q <= (rise_q || timeout) ? '0 : since_q + 1'b1;
            if (state_q == ST_ARM) begin
                win_q  <= '0;
                edge_q <= '0;
            end else if (rise_q) begin
                if (win_done) begin
                    win_q  <= '0;
                    edge_q <= '0;
                end else begin
                    win_q  <= win_inc;
                    edge_q <= edge_q + 1'b1;
                end
            end else begin
                win_q <= win_inc;
            end
        end
    end

    // Window end starts the divide only if the divider is free; otherwise that
    // result is dropped while the window still restarts.
    seq_udiv #(
        .W (DIV_W)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (win_done),
        .abort    (!en),
        .dividend (DIV_NUM + DIV_W'(per_next >> 1)),
        .divisor  (DIV_W'(per_next)),
        .quotient (div_quo),
        .done     (div_done),
        .busy     (div_busy)
    );

    // Result registers: divider completion or timeout updates and pulses freq_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            freq_khz   <= '0;
            period_cyc <= '0;
            freq_valid <= 1'b0;
            no_signal  <= 1'b0;
        end else begin
            freq_valid <= 1'b0;
            if (win_done) begin
                period_cyc <= per_next;
            end
            if (div_done && en) begin
                freq_khz   <= sat_freq(div_quo);
                no_signal  <= 1'b0;
                freq_valid <= 1'b1;
            end
            if (timeout) begin
                freq_khz   <= '0;
                no_signal  <= 1'b1;
                freq_valid <= 1'b1;
            end
        end
    end

    assign busy = div_busy | div_done;

endmodule

// File: tb/tb_am_freq_meter.sv
// Randomised tone bench for am_freq_meter against a timestamp-based reference model.
module tb_am_freq_meter;

    localparam int  CLK_K = 512;
    localparam int  NP    = 4;
    localparam int  HY    = 16;
    localparam int  TMO   = 2048;
    localparam int  MID   = 512;
    localparam real PI    = 3.14159265358979;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b1;
    logic        en        = 1'b0;
    logic [9:0]  demod_in  = '0;
    logic        din_valid = 1'b0;
    logic [7:0]  freq_khz;
    logic [19:0] period_cyc;
    logic        freq_valid;
    logic        no_signal;
    logic        busy;

    am_freq_meter #(
        .CLK_KHZ     (CLK_K),
        .NPER        (NP),
        .HYST        (HY),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .demod_in   (demod_in),
        .din_valid  (din_valid),
        .freq_khz   (freq_khz),
        .period_cyc (period_cyc),
        .freq_valid (freq_valid),
        .no_signal  (no_signal),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        bit is_to;
        int freq;
        int start;
    } exp_t;

    exp_t expq[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    // stimulus controls
    real  tone_f = 1.0;
    real  tone_a = 300.0;
    real  tone_ph = 0.0;
    int   noise_amp = 0;
    int   invalid_pct = 0;
    bit   en_drv = 1'b0;
    bit   rst_drv = 1'b0;

    // reference model state
    bit   m_sch = 1'b0;
    bit   rise_pend = 1'b0;
    int   mst = 0;          // 0 off, 1 waiting for first rise, 2 inside a window
    int   ref_t = 0;
    int   win_t = 0;
    int   edges = 0;
    int   last_start = -1000;
    int   m_freq = 0;
    int   m_nosig = 0;
    int   m_period = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    function automatic int exp_freq(input int per);
        int q;
        q = (CLK_K * NP + per / 2) / per;
        return (q > 255) ? 255 : q;
    endfunction

    task automatic push_item(input int due, input bit is_to, input int freq, input int start);
        exp_t it;
        it.due   = due;
        it.is_to = is_to;
        it.freq  = freq;
        it.start = start;
        expq.push_back(it);
    endtask

    // One clock: check outputs, drive the next sample, advance the model by one edge.
    task automatic tick();
        int   x;
        int   per;
        bit   vld;
        bit   rise_now;
        exp_t it;
        @(negedge clk);
        cyc++;
        if (cyc > 2) begin
            if (expq.size() > 0 && !expq[0].is_to && cyc == expq[0].start + 1)
                check("busy_start", busy, 1);
            if (expq.size() > 0 && !expq[0].is_to && cyc == expq[0].due - 1)
                check("busy_last", busy, 1);
            if (expq.size() > 0 && expq[0].due == cyc) begin
                it = expq.pop_front();
                check("fv_pulse", freq_valid, 1);
                m_freq  = it.freq;
                m_nosig = it.is_to ? 1 : 0;
            end else begin
                check("fv_quiet", freq_valid, 0);
            end
            check("freq_khz", freq_khz, m_freq);
            check("no_signal", no_signal, m_nosig);
            check("period_cyc", period_cyc, m_period);
        end

        vld = ($urandom_range(99) >= invalid_pct);
        if (vld) begin
            x = MID + $rtoi($floor(tone_a * $sin(2.0 * PI * tone_f * cyc / CLK_K + tone_ph) + 0.5));
            if (noise_amp > 0)
                x = x + int'($urandom_range(2 * noise_amp)) - noise_amp;
            if (x < 0) x = 0;
            if (x > 1023) x = 1023;
        end else begin
            x = int'($urandom_range(1023));
        end
        demod_in  = 10'(x);
        din_valid = vld;
        en        = en_drv;
        rst_n     = rst_drv;

        if (!rst_drv) begin
            m_sch = 0; rise_pend = 0; mst = 0; last_start = -1000;
            m_freq = 0; m_nosig = 0; m_period = 0;
            expq.delete();
        end else begin
            rise_now  = rise_pend;
            rise_pend = 0;
            if (vld) begin
                if (x >= MID + HY) begin
                    if (!m_sch) rise_pend = 1;
                    m_sch = 1;
                end else if (x < MID - HY) begin
                    m_sch = 0;
                end
            end
            if (!en_drv) begin
                mst = 0;
                last_start = -1000;
                for (int i = expq.size() - 1; i >= 0; i--)
                    if (expq[i].due > cyc) expq.delete(i);
            end else if (mst == 0) begin
                mst = 1;
                ref_t = cyc;
            end else if (rise_now) begin
                ref_t = cyc;
                if (mst == 1) begin
                    mst = 2; edges = 0; win_t = cyc;
                end else begin
                    edges++;
                    if (edges == NP) begin
                        per = cyc - win_t;
                        m_period = per;
                        if (cyc - last_start >= 34) begin
                            push_item(cyc + 35, 1'b0, exp_freq(per), cyc);
                            last_start = cyc;
                        end
                        win_t = cyc;
                        edges = 0;
                    end
                end
            end else if (cyc - ref_t == TMO) begin
                push_item(cyc + 1, 1'b1, 0, cyc);
                mst = 1;
                ref_t = cyc;
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_tone(input real f, input real a, input int nz, input int inv);
        tone_f      = f;
        tone_a      = a;
        noise_amp   = nz;
        invalid_pct = inv;
        tone_ph     = $urandom_range(628) / 100.0;
    endtask

    initial begin
        bit found;
        rst_drv = 1'b0;
        en_drv  = 1'b1;
        set_tone(1.0, 300.0, 0, 0);
        run(5);
        check("rst_freq", freq_khz, 0);
        check("rst_period", period_cyc, 0);
        check("rst_valid", freq_valid, 0);
        check("rst_nosig", no_signal, 0);
        check("rst_busy", busy, 0);
        rst_drv = 1'b1;

        run(9000);
        check("tone1k_freq", freq_khz, 1);
        check("tone1k_period", period_cyc, 2048);

        set_tone(5.0, 300.0, 0, 0);
        run(3000);
        check("tone5k_freq", freq_khz, 5);
        set_tone(3.0, 300.0, 0, 0);
        run(3000);
        check("tone3k_freq", freq_khz, 3);

        repeat (2) begin
            set_tone(1.0 + $urandom_range(4000) / 1000.0, 100.0 + $urandom_range(300), 0, 5);
            run(3000);
        end

        set_tone(1.0, 10.0, 0, 0);
        run(5000);
        check("weak_freq", freq_khz, 0);
        check("weak_nosig", no_signal, 1);

        set_tone(2.0, 300.0, 0, 0);
        run(4000);
        check("tone2k_freq", freq_khz, 2);
        check("tone2k_nosig", no_signal, 0);
        check("tone2k_period", period_cyc, 1024);

        set_tone(1.0, 300.0, 12, 10);
        run(7000);
        check("noisy_freq", freq_khz, 1);

        run(1000);
        en_drv = 1'b0;
        run(100);
        en_drv = 1'b1;

        found = 1'b0;
        for (int i = 0; i < 5000 && !found; i++) begin
            if (expq.size() > 0 && !expq[0].is_to && cyc >= expq[0].start + 10) found = 1'b1;
            else tick();
        end
        check("wait_divide", found, 1);
        en_drv = 1'b0;
        run(100);
        en_drv = 1'b1;
        run(4500);

        run(1000);
        rst_drv = 1'b0;
        run(5);
        check("rstmid_freq", freq_khz, 0);
        check("rstmid_period", period_cyc, 0);
        rst_drv = 1'b1;
        run(4500);
        check("rearm_freq", freq_khz, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
